// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: packs decoded RV32I fields into instruction words and
// writes them to consecutive instruction-memory word addresses.
// Optional immediate range checking is enabled by defining ENC_RANGE_CHECK_EN.
module instr_encoder_loader #(
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [2:0]        in_kind,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [2:0]        funct3,
  input  logic [6:0]        funct7,
  input  logic [31:0]       imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] count
);

  localparam logic [2:0] K_R    = 3'd0;
  localparam logic [2:0] K_I    = 3'd1;
  localparam logic [2:0] K_LW   = 3'd2;
  localparam logic [2:0] K_SW   = 3'd3;
  localparam logic [2:0] K_BR   = 3'd4;
  localparam logic [2:0] K_LUI  = 3'd5;
  localparam logic [2:0] K_JAL  = 3'd6;
  localparam logic [2:0] K_JALR = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg;
  logic [ADDR_W-1:0]   count_reg;
  logic [31:0]         word_reg;
  logic                last_reg;
  logic [31:0]         enc_word;
  logic                range_ok;

  // Combinational encoder: scatter the fields into the word layout of each kind
  always_comb begin
    enc_word = '0;
    case (in_kind)
      K_R:    enc_word = {funct7, rs2, rs1, funct3, rd, 7'b0110011};
      K_I:    enc_word = {imm[11:0], rs1, funct3, rd, 7'b0010011};
      K_LW:   enc_word = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      K_SW:   enc_word = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      K_BR:   enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011};
      K_LUI:  enc_word = {imm[31:12], rd, 7'b0110111};
      K_JAL:  enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      K_JALR: enc_word = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      default: enc_word = '0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  logic               err_reg;
  assign imm_s = imm;

  // Immediate range check per instruction kind; a failing bundle is consumed but never written
  always_comb begin
    range_ok = 1'b1;
    case (in_kind)
      K_I, K_LW, K_SW, K_JALR:
        range_ok = (imm_s >= -32'sd2048) && (imm_s <= 32'sd2047);
      K_BR:
        range_ok = (imm_s >= -32'sd4096) && (imm_s <= 32'sd4094) && !imm[0];
      K_JAL:
        range_ok = (imm_s >= -32'sd1048576) && (imm_s <= 32'sd1048574) && !imm[0];
      K_LUI:
        range_ok = (imm[11:0] == 12'd0);
      default:
        range_ok = 1'b1;
    endcase
  end

  assign err = err_reg;
`else
  assign range_ok = 1'b1;
  assign err      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    imem_we    = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_next = S_ACCEPT;
      end
      S_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (range_ok)     state_next = S_WRITE;
          else if (in_last) state_next = S_DONE;
          else              state_next = S_ACCEPT;
        end
      end
      S_WRITE: begin
        imem_we    = 1'b1;
        state_next = last_reg ? S_DONE : S_ACCEPT;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: address pointer, word counter, captured word and last flag
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg   <= '0;
      count_reg <= '0;
      word_reg  <= '0;
      last_reg  <= 1'b0;
`ifdef ENC_RANGE_CHECK_EN
      err_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            ptr_reg   <= start_addr;
            count_reg <= '0;
`ifdef ENC_RANGE_CHECK_EN
            err_reg   <= 1'b0;
`endif
          end
        end
        S_ACCEPT: begin
          if (in_valid) begin
            if (range_ok) begin
              word_reg <= enc_word;
              last_reg <= in_last;
            end
`ifdef ENC_RANGE_CHECK_EN
            else begin
              err_reg <= 1'b1;
            end
`endif
          end
        end
        S_WRITE: begin
          // Natural modulo-2^ADDR_W wrap for both pointer and count
          ptr_reg   <= ptr_reg + ADDR_W'(1);
          count_reg <= count_reg + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign imem_addr  = ptr_reg;
  assign imem_wdata = word_reg;
  assign count      = count_reg;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed testbench for instr_encoder_loader (ADDR_W = 9).
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  start_addr;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [2:0]  in_kind;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        imem_we;
  logic [8:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  count;

  int vectors = 0;
  int miscompares = 0;

  instr_encoder_loader #(.ADDR_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_kind(in_kind), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .busy(busy), .done(done), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] k, input logic [4:0] d, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] im, input logic last);
    in_kind = k; rd = d; rs1 = s1; rs2 = s2;
    funct3 = f3; funct7 = f7; imm = im; in_last = last;
    in_valid = 1'b1;
  endtask

  // Wait (bounded) for in_ready, then let the handshake edge pass
  task automatic handshake(input string tag);
    int n = 0;
    while (!in_ready && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    step();
  endtask

  task automatic expect_write(input string tag, input logic [8:0] a, input logic [31:0] w);
    chk({tag, "_we"},   64'(imem_we),    64'd1);
    chk({tag, "_addr"}, 64'(imem_addr),  64'(a));
    chk({tag, "_word"}, 64'(imem_wdata), 64'(w));
    $display("write %s: addr=%h word=%h", tag, imem_addr, imem_wdata);
  endtask

  task automatic send(input string tag, input logic [2:0] k, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im, input logic last,
                      input logic [8:0] a, input logic [31:0] w);
    drive(k, d, s1, s2, f3, f7, im, last);
    handshake(tag);
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_write(tag, a, w);
  endtask

  task automatic do_start(input string tag, input logic [8:0] a);
    start = 1'b1;
    start_addr = a;
    step();
    start = 1'b0;
    chk({tag, "_busy"},  64'(busy),     64'd1);
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_count0"}, 64'(count),   64'd0);
  endtask

  // Called in the WRITE cycle of the last bundle
  task automatic end_session(input string tag, input logic [8:0] n);
    step();
    chk({tag, "_done"},  64'(done),    64'd1);
    chk({tag, "_count"}, 64'(count),   64'(n));
    chk({tag, "_we_off"}, 64'(imem_we), 64'd0);
    step();
    chk({tag, "_idle"},  64'({busy, done, in_ready}), 64'd0);
  endtask

  task automatic single(input string tag, input logic [2:0] k, input logic [4:0] d,
                        input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] im,
                        input logic [8:0] a, input logic [31:0] w);
    do_start(tag, a);
    send(tag, k, d, s1, s2, f3, f7, im, 1'b1, a, w);
    end_session(tag, 9'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; start_addr = 9'h155;
    in_valid = 1'b1; in_last = 1'b1; in_kind = 3'd0;
    rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0; funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;

    // Reset with start held high: everything stays zero
    repeat (3) begin
      step();
      chk("reset_outputs", 64'({in_ready, imem_we, busy, done, err, imem_addr, imem_wdata, count}), 64'd0);
    end
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    step();
    chk("idle_after_reset", 64'({in_ready, imem_we, busy, done, err, imem_addr, imem_wdata, count}), 64'd0);

    // Two-bundle session at 0x010
    do_start("s1", 9'h010);
    send("s1_addi", 3'd1, 5'd1, 5'd0, 5'd31, 3'b000, 7'h7f, 32'd5, 1'b0, 9'h010, 32'h00500093);
    step();
    chk("s1_back_to_accept", 64'(in_ready), 64'd1);
    chk("s1_count1", 64'(count), 64'd1);
    chk("s1_no_early_done", 64'(done), 64'd0);
    send("s1_add", 3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 1'b1, 9'h011, 32'h002081B3);
    end_session("s1", 9'd2);
    chk("wdata_hold", 64'(imem_wdata), 64'h002081B3);

    // Each format, unused fields driven with junk
    single("lw",       3'd2, 5'd2,  5'd1,  5'd31, 3'b101, 7'h7f, 32'd8,          9'h100, 32'h0080A103);
    single("sw",       3'd3, 5'd31, 5'd1,  5'd2,  3'b000, 7'h7f, 32'd4,          9'h101, 32'h0020A223);
    single("beq",      3'd4, 5'd31, 5'd0,  5'd0,  3'b000, 7'h7f, 32'd8,          9'h102, 32'h00000463);
    single("lui",      3'd5, 5'd5,  5'd31, 5'd31, 3'b111, 7'h7f, 32'h12345000,   9'h103, 32'h123452B7);
    single("jal",      3'd6, 5'd1,  5'd31, 5'd31, 3'b111, 7'h7f, 32'd16,         9'h104, 32'h010000EF);
    single("jalr",     3'd7, 5'd0,  5'd1,  5'd31, 3'b111, 7'h7f, 32'd0,          9'h105, 32'h00008067);
    single("beq_neg",  3'd4, 5'd31, 5'd0,  5'd0,  3'b000, 7'h7f, 32'hFFFFFFFC,   9'h106, 32'hFE000EE3);
    single("jal_neg",  3'd6, 5'd0,  5'd31, 5'd31, 3'b000, 7'h7f, 32'hFFFFFFFC,   9'h107, 32'hFFDFF06F);
    single("addi_neg", 3'd1, 5'd1,  5'd0,  5'd31, 3'b000, 7'h7f, 32'hFFFFFFFF,   9'h108, 32'hFFF00093);
    single("sub",      3'd0, 5'd5,  5'd6,  5'd7,  3'b000, 7'h20, 32'hFFFFFFFF,   9'h109, 32'h407302B3);
    single("bne",      3'd4, 5'd31, 5'd1,  5'd2,  3'b001, 7'h7f, 32'd8,          9'h10A, 32'h00209463);

    // Pointer wrap-around
    do_start("wrap", 9'h1FF);
    send("wrap_w0", 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b0, 9'h1FF, 32'h00500093);
    step();
    chk("wrap_count1", 64'(count), 64'd1);
    send("wrap_w1", 3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 1'b1, 9'h000, 32'h002081B3);
    end_session("wrap", 9'd2);

    // in_valid held through WRITE: exactly one write per handshake
    do_start("bp", 9'h020);
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b0);
    handshake("bp_h0");
    expect_write("bp_w0", 9'h020, 32'h00500093);
    step();
    chk("bp_no_extra_we", 64'(imem_we), 64'd0);
    chk("bp_ready", 64'(in_ready), 64'd1);
    chk("bp_count1", 64'(count), 64'd1);
    drive(3'd0, 5'd3, 5'd1, 5'd2, 3'b000, 7'h00, 32'd0, 1'b1);
    step();
    expect_write("bp_w1", 9'h021, 32'h002081B3);
    in_valid = 1'b0; in_last = 1'b0;
    end_session("bp", 9'd2);

    // Reset asserted during WRITE: abandon, no done
    do_start("rst", 9'h030);
    send("rst_w", 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b1, 9'h030, 32'h00500093);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_idle", 64'({busy, done, imem_we, in_ready}), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    step();
    chk("rst_no_done", 64'({busy, done}), 64'd0);

    // start during a session is ignored
    do_start("ign", 9'h040);
    start = 1'b1; start_addr = 9'h050;
    step();
    start = 1'b0;
    chk("ign_still_accept", 64'(in_ready), 64'd1);
    send("ign_w", 3'd7, 5'd0, 5'd1, 5'd0, 3'b000, 7'h00, 32'd0, 1'b1, 9'h040, 32'h00008067);
    end_session("ign", 9'd1);

`ifdef ENC_RANGE_CHECK_EN
    // Out-of-range immediate: consumed, not written, err set
    do_start("rc", 9'h060);
    drive(3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd4096, 1'b0);
    handshake("rc_bad");
    in_valid = 1'b0;
    chk("rc_no_we", 64'(imem_we), 64'd0);
    chk("rc_err", 64'(err), 64'd1);
    chk("rc_ready", 64'(in_ready), 64'd1);
    chk("rc_count", 64'(count), 64'd0);
    send("rc_good", 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b1, 9'h060, 32'h00500093);
    end_session("rc", 9'd1);
    chk("rc_err_sticky", 64'(err), 64'd1);
    do_start("rc_clr", 9'h070);
    chk("rc_err_cleared", 64'(err), 64'd0);
    send("rc_clr_w", 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd5, 1'b1, 9'h070, 32'h00500093);
    end_session("rc_clr", 9'd1);
`else
    // Without checking, out-of-range bits are truncated and err stays low
    single("trunc", 3'd1, 5'd1, 5'd0, 5'd0, 3'b000, 7'h00, 32'd4096, 9'h060, 32'h00000093);
    chk("trunc_err", 64'(err), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

Sequential RISC-V instruction encoder and program loader. It accepts decoded instruction fields over a valid/ready handshake and packs them into 32-bit RV32I words for the same opcode set the pipeline decoder handles: R-type, I-type ALU, LW, SW, BEQ-class branch, LUI, JAL and JALR. It writes each word into the instruction-memory write port at consecutive word addresses. It sits beside instruction memory and lets benches and the boot path load programs without precompiled hex files.

## Interface
- ADDR_W, 9, instruction-memory word-address width.
- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a load session at `start_addr`. Ignored unless the block is IDLE.
- start_addr  in  ADDR_W  first word address of the session.
- in_valid  in  1  the field bundle is valid.
- in_ready  out  1  the block can accept a bundle.
- in_last  in  1  this bundle is the last one of the session.
- in_kind  in  3  instruction kind: 0 R, 1 I-ALU, 2 LW, 3 SW, 4 BR, 5 LUI, 6 JAL, 7 JALR.
- rd, rs1, rs2  in  5 each  register indices.
- funct3  in  3  funct3 field. Used for R, I-ALU and BR. Forced to 010 for LW/SW and to 000 for JALR.
- funct7  in  7  funct7 field. Used for R only.
- imm  in  32  signed byte immediate. For LUI it is the full upper value.
- imem_we  out  1  write strobe to instruction memory.
- imem_addr  out  ADDR_W  write word address.
- imem_wdata  out  32  encoded instruction word.
- busy  out  1  a session is active.
- done  out  1  one-cycle pulse at the end of a session.
- err  out  1  sticky immediate-range error. Cleared by `start`. Only present when the configuration macro is defined; tied to 0 otherwise.
- count  out  ADDR_W  number of words written in the current or last session.

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE: `start` latches `start_addr` into the address pointer, clears `count` and `err`, then moves to ACCEPT.
- ACCEPT:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, the block registers the encoded word and `in_last`, then moves to WRITE.
- WRITE:
  - `imem_we` = 1 for exactly one cycle, with `imem_addr` set to the pointer.
  - The pointer and `count` then increment by 1.
  - Next state is DONE if the registered last flag is set, otherwise ACCEPT.
- DONE: `done` = 1 for one cycle, then the block returns to IDLE.
- `busy` = 1 in ACCEPT, WRITE and DONE.
- Encodings (bit fields high to low, all fields taken from `imm`):
  - R: funct7 | rs2 | rs1 | funct3 | rd | 0110011.
  - I-ALU: imm[11:0] | rs1 | funct3 | rd | 0010011.
  - LW: imm[11:0] | rs1 | 010 | rd | 0000011.
  - SW: imm[11:5] | rs2 | rs1 | 010 | imm[4:0] | 0100011.
  - BR: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | 1100011.
  - LUI: imm[31:12] | rd | 0110111.
  - JAL: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | 1101111.
  - JALR: imm[11:0] | rs1 | 000 | rd | 1100111.
- Fields a kind does not use are ignored.
- Pointer wrap-around: after the word at address 2^ADDR_W−1, the pointer wraps to 0 with no error. `count` wraps the same way.

## Timing
- Reset values: state IDLE; `in_ready`, `imem_we`, `busy`, `done` and `err` all 0; `imem_addr`, `imem_wdata` and `count` all 0.
- Reset mid-session: the FSM returns to IDLE next cycle. The partial load is abandoned. There is no pending write and no `done`.
- Latency:
  - Handshake cycle N puts `imem_we` high in cycle N+1.
  - For the last bundle, `done` is high in cycle N+2.
  - Throughput is one word per 2 cycles.
- `in_ready` depends only on state, never on `in_valid`.
- `start` during a session is ignored. `start` and `reset` in the same cycle: reset wins.
- Outputs are registered. `imem_wdata` holds its last value outside WRITE.

## Configuration
- Macro `ENC_RANGE_CHECK_EN`.
- Defined: before encoding, the block checks the immediate against the kind's range:
  - I-ALU, LW, SW, JALR: imm must lie in [−2048, 2047].
  - BR: imm in [−4096, 4094] and imm[0] = 0.
  - JAL: imm in [−2^20, 2^20−2] and imm[0] = 0.
  - LUI: imm[11:0] = 0.
  - R: no check.
  - On a failing bundle: accept it, skip WRITE, set `err`, leave the pointer and `count` unchanged, and go to DONE if `in_last` is set, otherwise back to ACCEPT.
- Undefined: no checks; out-of-range bits are silently truncated; `err` is tied to 0.

## Test plan
- Reset with `start` held high → the block stays IDLE, and all outputs are 0 for the whole reset.
- Session at `start_addr` 0x010 with two bundles:
  - addi x1,x0,5 → word 0x00500093 at 0x010.
  - add x3,x1,x2 with in_last → word 0x002081B3 at 0x011.
  - Then `done` pulses and `count` = 2.
- Formats, each a single bundle:
  - lw x2,8(x1) → 0x0080A103.
  - sw x2,4(x1) → 0x0020A223.
  - beq x0,x0,8 → 0x00000463.
  - lui x5,0x12345000 → 0x123452B7.
  - jal x1,16 → 0x010000EF.
  - jalr x0,0(x1) → 0x00008067.
- Wrap-around with ADDR_W = 9: `start_addr` 0x1FF and 2 bundles → writes land at 0x1FF then 0x000.
- Back-pressure and reset: hold `in_valid` through WRITE → exactly one write per handshake. Assert reset during WRITE → no `done`, and the block is IDLE next cycle.
- With `ENC_RANGE_CHECK_EN`:
  - addi with imm = 4096 → no write, `err` = 1, `count` unchanged.
  - A following `start` clears `err`.
